// File: rtl/gate_pkg.sv
// Shared types for the logic gate unit:
// op encodings, sweep states, golden table and a 1-bit gate evaluator.
package gate_pkg;

   typedef enum logic [2:0] {
      OP_AND   = 3'd0,
      OP_OR    = 3'd1,
      OP_NAND  = 3'd2,
      OP_NOR   = 3'd3,
      OP_XOR   = 3'd4,
      OP_XNOR  = 3'd5,
      OP_NOT_A = 3'd6,
      OP_NOT_B = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [31:0] GOLDEN_TT = 32'h539617E8;

   // Single-bit evaluator; wider operands apply it per bit.
   function automatic logic gate_eval(
      input op_e  op,
      input logic a,
      input logic b
   );
      logic r;
      case (op)
         OP_AND:   r = a & b;
         OP_OR:    r = a | b;
         OP_NAND:  r = ~(a & b);
         OP_NOR:   r = ~(a | b);
         OP_XOR:   r = a ^ b;
         OP_XNOR:  r = ~(a ^ b);
         OP_NOT_A: r = ~a;
         OP_NOT_B: r = ~b;
         default:  r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/gate_eval_comb.sv
// Combinational WIDTH-bit gate evaluator.
// Ports: op_i select, a_i/b_i operands, y_o bitwise result.
module gate_eval_comb
   import gate_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  op_e              op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] y_o
);

   always_comb begin
      y_o = '0;
      for (int k = 0; k < WIDTH; k++) begin
         y_o[k] = gate_eval(op_i, a_i[k], b_i[k]);
      end
   end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered bitwise gate unit with valid/ready handshake and truth-table
// sweep engine. Ports: clk/rst, in_valid/in_ready/a/b/op operand side,
// out_valid/out_ready/y result side, sweep_start/busy/done, tt_table,
// sweep_pass.
module logic_gate_unit
   import gate_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   input  logic             sweep_start,
   output logic             sweep_busy,
   output logic             sweep_done,
   output logic [31:0]      tt_table,
   output logic             sweep_pass
);

   state_e           state_q, state_d;
   logic [4:0]       idx_q, idx_d;
   logic [31:0]      tt_q, tt_d;
   logic             pass_q, pass_d;
   logic             vld_q, vld_d;
   logic [WIDTH-1:0] y_q, y_d;

   logic [WIDTH-1:0] dir_y;
   logic             sw_y;
   logic             xfer;

   gate_eval_comb #(.WIDTH(WIDTH)) u_dir (
      .op_i (op_e'(op)),
      .a_i  (a),
      .b_i  (b),
      .y_o  (dir_y)
   );

   // Sweep row: a-bit is idx[1], b-bit is idx[0].
   gate_eval_comb #(.WIDTH(1)) u_sweep (
      .op_i (op_e'(idx_q[4:2])),
      .a_i  (idx_q[1]),
      .b_i  (idx_q[0]),
      .y_o  (sw_y)
   );

   assign sweep_busy = (state_q != ST_IDLE);
   assign sweep_done = (state_q == ST_DONE);
   assign in_ready   = !rst && !sweep_busy &&
                       (!vld_q || out_ready);
   assign xfer       = in_valid && in_ready;

   assign out_valid  = vld_q;
   assign y          = y_q;
   assign tt_table   = tt_q;
   // Pass is visible already in the done cycle, then held.
   assign sweep_pass = pass_q ||
                       (sweep_done && tt_q == GOLDEN_TT);

   always_comb begin
      vld_d = vld_q;
      y_d   = y_q;
      if (xfer) begin
         vld_d = 1'b1;
         y_d   = dir_y;
      end else if (out_ready) begin
         vld_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tt_d    = tt_q;
      pass_d  = pass_q;
      case (state_q)
         ST_IDLE: begin
            if (sweep_start) begin
               tt_d    = '0;
               pass_d  = 1'b0;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            tt_d[idx_q] = sw_y;
            idx_d       = idx_q + 5'd1;
            if (idx_q == 5'd31) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            pass_d  = (tt_q == GOLDEN_TT);
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         tt_q    <= '0;
         pass_q  <= 1'b0;
         vld_q   <= 1'b0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tt_q    <= tt_d;
         pass_q  <= pass_d;
         vld_q   <= vld_d;
         y_q     <= y_d;
      end
   end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit:
// directed handshake/sweep cases plus randomized scoreboard run.
module tb_logic_gate_unit;

   localparam int W = 8;
   localparam logic [31:0] GOLD = 32'h539617E8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [2:0]   op = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] y;
   logic         sweep_start = 1'b0;
   logic         sweep_busy;
   logic         sweep_done;
   logic [31:0]  tt_table;
   logic         sweep_pass;

   int n_chk = 0;
   int n_err = 0;

   // Truth table per op, bit index = {a,b}.
   logic [3:0] nib [8] = '{4'h8, 4'hE, 4'h7, 4'h1,
                           4'h6, 4'h9, 4'h3, 4'h5};

   logic [W-1:0] exp_dir [8] = '{8'hC0, 8'hFC, 8'h3F, 8'h03,
                                 8'h3C, 8'hC3, 8'h0F, 8'h33};

   logic [W-1:0] sb_q [$];
   int           m_busy;

   always #5 clk = ~clk;

   logic_gate_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .op          (op),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .y           (y),
      .sweep_start (sweep_start),
      .sweep_busy  (sweep_busy),
      .sweep_done  (sweep_done),
      .tt_table    (tt_table),
      .sweep_pass  (sweep_pass)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [W-1:0] ref_f(
      input int op_n,
      input logic [W-1:0] av,
      input logic [W-1:0] bv
   );
      logic [W-1:0] r;
      logic [3:0]   t;
      t = nib[op_n];
      for (int k = 0; k < W; k++) begin
         r[k] = t[{av[k], bv[k]}];
      end
      return r;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, "_vld"}, out_valid, 0);
      chk({tag, "_y"}, y, 0);
      chk({tag, "_busy"}, sweep_busy, 0);
      chk({tag, "_done"}, sweep_done, 0);
      chk({tag, "_tt"}, tt_table, 0);
      chk({tag, "_pass"}, sweep_pass, 0);
   endtask

   // Called with the sweep already started (busy visible now).
   task automatic sweep_wait(input int re_at,
                             input int drain_at,
                             input int hold_y);
      int busy_n;
      int done_n;
      int done_at;
      busy_n  = 0;
      done_n  = 0;
      done_at = 0;
      for (int c = 1; c <= 80 && sweep_busy; c++) begin
         busy_n++;
         chk("sw_rdy", in_ready, 0);
         if (sweep_done) begin
            done_n++;
            done_at = c;
            chk("sw_tt", tt_table, GOLD);
            chk("sw_pass_done", sweep_pass, 1);
         end
         if (hold_y >= 0) begin
            if (c <= drain_at) begin
               chk("sw_hold_v", out_valid, 1);
               chk("sw_hold_y", y, hold_y);
            end else begin
               chk("sw_blk_v", out_valid, 0);
            end
         end
         sweep_start = (c == re_at);
         if (c == drain_at) out_ready = 1'b1;
         step();
      end
      sweep_start = 1'b0;
      chk("sw_busy_n", busy_n, 33);
      chk("sw_done_n", done_n, 1);
      chk("sw_done_at", done_at, 33);
      chk("sw_tt_after", tt_table, GOLD);
      chk("sw_pass_after", sweep_pass, 1);
   endtask

   initial begin
      @(negedge clk);
      step();
      chk_reset("rst");
      chk("rst_rdy", in_ready, 0);
      rst = 1'b0;
      step();
      chk("rel_rdy", in_ready, 1);
      chk_reset("rel");

      // ops 0..7 back-to-back
      out_ready = 1'b1;
      a = 8'hF0;
      b = 8'hCC;
      in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         op = 3'(k);
         step();
         chk($sformatf("dir%0d_v", k), out_valid, 1);
         chk($sformatf("dir%0d_y", k), y, exp_dir[k]);
      end
      in_valid = 1'b0;
      step();
      chk("dir_drain", out_valid, 0);

      // backpressure
      out_ready = 1'b0;
      in_valid = 1'b1;
      op = 3'd0;
      a = 8'hFF;
      b = 8'h0F;
      step();
      op = 3'd1;
      a = 8'h00;
      b = 8'hF0;
      for (int k = 0; k < 3; k++) begin
         chk("bp_y", y, 8'h0F);
         chk("bp_v", out_valid, 1);
         chk("bp_rdy", in_ready, 0);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_rdy_go", in_ready, 1);
      step();
      chk("bp_new_v", out_valid, 1);
      chk("bp_new_y", y, 8'hF0);
      in_valid = 1'b0;
      step();
      chk("bp_empty", out_valid, 0);

      // plain sweep, then one with re-assert in RUN
      sweep_start = 1'b1;
      step();
      sweep_start = 1'b0;
      sweep_wait(0, 0, -1);
      chk("sw1_rdy", in_ready, 1);
      sweep_start = 1'b1;
      step();
      sweep_start = 1'b0;
      sweep_wait(5, 0, -1);

      // reset at RUN index 10 with a pending result
      out_ready = 1'b0;
      in_valid = 1'b1;
      op = 3'd0;
      a = 8'hFF;
      b = 8'hFF;
      step();
      in_valid = 1'b0;
      sweep_start = 1'b1;
      step();
      sweep_start = 1'b0;
      for (int c = 1; c < 11; c++) step();
      chk("mid_busy", sweep_busy, 1);
      rst = 1'b1;
      step();
      chk_reset("mrst");
      chk("mrst_rdy", in_ready, 0);
      rst = 1'b0;
      out_ready = 1'b1;
      step();
      sweep_start = 1'b1;
      step();
      sweep_start = 1'b0;
      sweep_wait(0, 0, -1);

      // pending result held and drained in sweep
      out_ready = 1'b0;
      in_valid = 1'b1;
      op = 3'd4;
      a = 8'hA5;
      b = 8'h0F;
      step();
      op = 3'd7;
      a = 8'h00;
      b = 8'h3C;
      sweep_start = 1'b1;
      step();
      sweep_start = 1'b0;
      sweep_wait(0, 10, 8'hAA);
      chk("post_rdy", in_ready, 1);
      step();
      chk("post_v", out_valid, 1);
      chk("post_y", y, 8'hC3);
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();

      // operand and sweep_start together in IDLE
      in_valid = 1'b1;
      sweep_start = 1'b1;
      op = 3'd5;
      a = 8'h0F;
      b = 8'h33;
      step();
      in_valid = 1'b0;
      sweep_start = 1'b0;
      chk("both_v", out_valid, 1);
      chk("both_y", y, 8'hC3);
      chk("both_busy", sweep_busy, 1);
      sweep_wait(0, 0, -1);
      step();

      // randomized scoreboard run
      sb_q.delete();
      m_busy = 0;
      for (int t = 0; t < 400; t++) begin
         chk("r_vld", out_valid, sb_q.size() != 0);
         if (sb_q.size() != 0) chk("r_y", y, sb_q[0]);
         chk("r_busy", sweep_busy, m_busy > 0);
         chk("r_done", sweep_done, m_busy == 1);
         in_valid    = ($urandom_range(0, 3) != 0);
         out_ready   = ($urandom_range(0, 2) != 0);
         a           = W'($urandom);
         b           = W'($urandom);
         op          = 3'($urandom_range(0, 7));
         sweep_start = (t < 300) &&
                       ($urandom_range(0, 63) == 0);
         #1;
         begin
            logic rdy_e;
            rdy_e = (m_busy == 0) &&
                    (sb_q.size() == 0 || out_ready);
            chk("r_rdy", in_ready, rdy_e);
            if (sb_q.size() != 0 && out_ready)
               void'(sb_q.pop_front());
            if (rdy_e && in_valid)
               sb_q.push_back(ref_f(int'(op), a, b));
            if (m_busy > 0) m_busy--;
            else if (sweep_start) m_busy = 33;
         end
         step();
      end
      in_valid = 1'b0;
      sweep_start = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
